fm_wrbuf: RTL
=============

# fm_wrbuf

Write buffer between the CPU bus and the FM synthesizer's register port. The synthesizer stalls register writes for roughly 130 of every 506 clocks while it sweeps its 64 operators. This block absorbs CPU writes into a FIFO so the CPU stalls only when the buffer is full. It drains the queued writes in order whenever the synthesizer accepts them. CPU reads pass through to the synthesizer, and are held off until all earlier writes have landed.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries. Legal range is 1..6.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_addr` in 8: CPU register address.
- `cpu_wrdata` in 32: CPU write data.
- `cpu_wren` in 1: CPU write request. It is held until `cpu_wait` is low.
- `cpu_rden` in 1: CPU read request. It is held until `cpu_wait` is low.
- `cpu_rddata` out 32: read data.
- `cpu_wait` out 1: stall for the current CPU request.
- `fm_addr` out 8: address to the synthesizer.
- `fm_wrdata` out 32: write data to the synthesizer.
- `fm_wren` out 1: write request to the synthesizer.
- `fm_wait` in 1: synthesizer stall. It is only meaningful while `fm_wren` is high.
- `fm_rddata` in 32: synthesizer read data (combinational from `fm_addr`).
- `level` out DEPTH_LOG2+1: number of occupied entries.
- `empty` out 1: `level == 0`.

## Operation
- Each entry is {addr[7:0], data[31:0]}, 40 bits wide.
- Write and read pointers are DEPTH_LOG2+1 bits wide and wrap naturally.
  - `level` = wr_ptr − rd_ptr.
  - full = `level == 2^DEPTH_LOG2`.
- Push occurs when `cpu_wren && !full`. The entry is written at wr_ptr and wr_ptr increments.
- Pop occurs when `fm_wren && !fm_wait`, and rd_ptr increments.
- `cpu_wait` = (`cpu_wren` && full) || (`cpu_rden` && !empty).
  - There is no same-cycle bypass: a full FIFO stalls the CPU even if a pop happens that cycle.
  - Reads wait until the FIFO is empty, which guarantees read-after-write ordering.
- Drain-side outputs:
  - `fm_wren` = !empty.
  - When non-empty, `fm_addr`/`fm_wrdata` come from the head entry, read asynchronously from storage.
  - When empty, `fm_addr` = `cpu_addr` and `fm_wrdata` = 0.
- `cpu_rddata` = `fm_rddata` when `cpu_rden` && empty, otherwise 0.
- Push and pop in the same cycle: both pointers advance and `level` is unchanged.
- Push into an empty FIFO: the entry appears on the `fm_*` outputs the next cycle.
- The block never drops, merges or reorders writes.

## Timing
- Reset values: pointers 0, `level` = 0, `empty` = 1, `fm_wren` = 0, `fm_wrdata` = 0, `cpu_wait` = `cpu_wren`·0 + `cpu_rden`·0 = 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all pending entries immediately (asynchronously); `fm_wren` drops in the same instant.
- Latency:
  - Write accepted → presented to the synthesizer: 1 clock.
  - Back-to-back drain: 1 entry per clock while `fm_wait` = 0.
- Read latency: combinational pass-through in the cycle where the FIFO is empty; the read completes in that cycle.
- `fm_wait` high: the head stays stable and `fm_wren` stays high; the pop happens on the first cycle `fm_wait` is low.
- Pointer wrap past 2^(DEPTH_LOG2+1) − 1 wraps to 0 with no effect on ordering.
- `cpu_wren` and `cpu_rden` both high is illegal. The bench asserts this never happens; RTL gives write priority (`cpu_rddata` = 0).

## Structure
- Shared package `fm_pkg`:
  - `FM_ADDR_W` = 8, `FM_DATA_W` = 32.
  - `FM_WRBUF_ENTRY_W` = 40.
  - Packed entry type {addr, data}.
- One sub-module: `fm_wrbuf_mem`, a simple dual-port distributed RAM.
  - Parameterized depth.
  - Synchronous write, asynchronous read.
  - Holds the entry storage.
- Pointer, level and handshake logic live in the top module.

## Test plan
- Idle synthesizer: write addr 0x02, data 0x0000_0001.
  - → `fm_wren` high 1 clock later with the same addr/data.
  - → pop that cycle; `level` returns to 0.
- Hold `fm_wait` = 1 for 130 clocks, issue 16 writes with `DEPTH_LOG2` = 4.
  - → all accepted with `cpu_wait` = 0, `level` = 16.
  - → a 17th write sees `cpu_wait` = 1 until the first pop after `fm_wait` drops.
- Queue 3 writes to 0x80..0x82, then a read of 0x02.
  - → `cpu_wait` stays high for 3 drain clocks.
  - → the read returns `fm_rddata` in the first cycle `empty` = 1.
- Push and pop every cycle for 100 clocks.
  - → `level` constant at 1.
  - → the `fm_*` write sequence equals the CPU write sequence, including across pointer wrap.
- Assert `reset_n` low with `level` = 9.
  - → `fm_wren` = 0 and `level` = 0 immediately.
  - → none of the 9 entries reach the synthesizer after release.
- Random CPU writes/reads against a behavioural fmsynth model with a 506-clock frame.
  - → the scoreboard matches write order.
  - → reads return values reflecting all earlier writes.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared FM synthesizer bus widths and the write-buffer entry format.
package fm_pkg;

  localparam int FM_ADDR_W        = 8;
  localparam int FM_DATA_W        = 32;
  localparam int FM_WRBUF_ENTRY_W = FM_ADDR_W + FM_DATA_W;

  // One queued register write; addr occupies the upper byte of the 40-bit word.
  typedef struct packed {
    logic [FM_ADDR_W-1:0] addr;
    logic [FM_DATA_W-1:0] data;
  } fm_entry_t;

endpackage

// File: rtl/fm_wrbuf_mem.sv
// Entry storage for the write buffer: simple dual-port RAM with a
// synchronous write port and an asynchronous read port, so the FIFO head
// is visible on the drain side without a read-latency stage.
module fm_wrbuf_mem
  import fm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  fm_entry_t             wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output fm_entry_t             rdata
);

  // Contents are never reset; the pointers define which entries are live.
  fm_entry_t mem [2**DEPTH_LOG2];

  // Write port: store the pushed entry at the write pointer.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fm_wrbuf.sv
// CPU -> FM synthesizer write buffer. CPU writes are queued and drained in
// order whenever the synthesizer is not stalling; CPU reads pass straight
// through but are held off until every queued write has landed.
module fm_wrbuf
  import fm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4   // legal 1..6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FM_ADDR_W-1:0]  cpu_addr,
  input  logic [FM_DATA_W-1:0]  cpu_wrdata,
  input  logic                  cpu_wren,
  input  logic                  cpu_rden,
  output logic [FM_DATA_W-1:0]  cpu_rddata,
  output logic                  cpu_wait,
  output logic [FM_ADDR_W-1:0]  fm_addr,
  output logic [FM_DATA_W-1:0]  fm_wrdata,
  output logic                  fm_wren,
  input  logic                  fm_wait,
  input  logic [FM_DATA_W-1:0]  fm_rddata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty
);

  localparam int                PTR_W    = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0]  FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  // The extra pointer MSB distinguishes full from empty; both wrap freely.
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, push, pop;
  fm_entry_t        head, wentry;

  assign level  = wr_ptr - rd_ptr;
  assign empty  = (level == '0);
  assign full   = (level == FULL_LVL);

  // No same-cycle bypass: a full buffer stalls the CPU even while popping.
  assign push   = cpu_wren && !full;
  assign pop    = fm_wren && !fm_wait;

  // Reads wait for an empty buffer, which gives read-after-write ordering.
  assign cpu_wait = (cpu_wren && full) || (cpu_rden && !empty);

  // Write has priority over an (illegal) simultaneous read.
  assign cpu_rddata = (cpu_rden && !cpu_wren && empty) ? fm_rddata : '0;

  assign wentry.addr = cpu_addr;
  assign wentry.data = cpu_wrdata;

  // When idle the synthesizer address follows the CPU so reads pass through.
  assign fm_wren   = !empty;
  assign fm_addr   = empty ? cpu_addr : head.addr;
  assign fm_wrdata = empty ? '0       : head.data;

  fm_wrbuf_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .wen   (push),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (wentry),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (head)
  );

  // Pointer update; async reset discards every pending entry at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
